// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
// One beat completes in any cycle where mem_req and mem_ack are both high.
interface mem_access_unit_if #(
  parameter int AW = 32
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: executes pipeline loads/stores over a 32-bit handshaked
// data-memory bus. Doublewords take two beats; byte lanes are steered and
// load data is sign/zero-extended to 64 bits. The core is stalled until done.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned word/doubleword accesses skip the bus and pulse
//                misalign together with done (rdata untouched)
//   undefined -> low address bits are ignored, misalign is tied to 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an access; stall asserted combinationally if one shows up
// BEAT0 | first (or only) bus beat outstanding
// BEAT1 | upper word of a doubleword outstanding
// DONE  | one-cycle completion, done=1, no new access accepted
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    memwrite,
  input  logic          memread,
  input  logic [2:0]    readtype,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [63:0]   rdata,
  output logic          misalign,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_BYTE, SZ_DWORD} size_t;

  state_t state_q, state_d;

  logic        access;
  logic        acc_write;
  size_t       acc_size;
  logic        acc_unsigned;
  logic        acc_misaligned;
  logic        beat_ack;

  logic        write_q;
  size_t       size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] lo_q;
  logic [63:0] load_ext;
  logic [7:0]  byte_sel;

  // Decode the incoming memory controls; a store takes priority over a load.
  always_comb begin
    access       = memread | (memwrite != 2'b00);
    acc_write    = (memwrite != 2'b00);
    acc_size     = SZ_WORD;
    acc_unsigned = 1'b0;
    if (acc_write) begin
      case (memwrite)
        2'b10:   acc_size = SZ_BYTE;
        2'b11:   acc_size = SZ_DWORD;
        default: acc_size = SZ_WORD;
      endcase
    end else begin
      case (readtype)
        3'b001: acc_unsigned = 1'b1;
        3'b010: acc_size = SZ_BYTE;
        3'b011: begin
          acc_size     = SZ_BYTE;
          acc_unsigned = 1'b1;
        end
        3'b100: acc_size = SZ_DWORD;
        default: begin
          acc_size     = SZ_WORD;
          acc_unsigned = 1'b0;
        end
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    acc_misaligned = ((acc_size == SZ_WORD)  && (addr[1:0] != 2'b00)) ||
                     ((acc_size == SZ_DWORD) && (addr[2:0] != 3'b000));
`else
    acc_misaligned = 1'b0;
`endif
  end

  // A beat only counts while a request is actually outstanding.
  assign beat_ack = bus.mem_req & bus.mem_ack;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus the core-facing handshake outputs.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = acc_misaligned ? DONE : BEAT0;
          stall   = 1'b1;
        end
      end
      BEAT0: begin
        stall = 1'b1;
        if (beat_ack) state_d = (size_q == SZ_DWORD) ? BEAT1 : DONE;
      end
      BEAT1: begin
        stall = 1'b1;
        if (beat_ack) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The IDLE term depends on live inputs, so keep stall low through reset.
    if (reset) stall = 1'b0;
  end

  // Capture access attributes on acceptance; they steer the beats and the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q    <= 1'b0;
      size_q     <= SZ_WORD;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      wdata_hi_q <= 32'h0;
    end else if ((state_q == IDLE) && access) begin
      write_q    <= acc_write;
      size_q     <= acc_size;
      unsigned_q <= acc_unsigned;
      lane_q     <= addr[1:0];
      wdata_hi_q <= wdata[63:32];
    end
  end

  // Registered bus outputs: held stable until ack, second beat follows the first ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && !acc_misaligned) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= acc_write;
            bus.mem_addr <= {addr[AW-1:2], 2'b00};
            if (acc_write && (acc_size == SZ_BYTE)) begin
              bus.mem_be    <= 4'b0001 << addr[1:0];
              bus.mem_wdata <= {4{wdata[7:0]}};
            end else begin
              bus.mem_be    <= 4'b1111;
              bus.mem_wdata <= acc_write ? wdata[31:0] : 32'h0;
            end
          end
        end
        BEAT0: begin
          if (beat_ack) begin
            if (size_q == SZ_DWORD) begin
              bus.mem_addr  <= bus.mem_addr + AW'(4);
              bus.mem_wdata <= write_q ? wdata_hi_q : 32'h0;
            end else begin
              bus.mem_req <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (beat_ack) bus.mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Lane select and extension of a single-beat load.
  always_comb begin
    load_ext = 64'h0;
    case (lane_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    if (size_q == SZ_BYTE) begin
      load_ext = unsigned_q ? {56'h0, byte_sel} : {{56{byte_sel[7]}}, byte_sel};
    end else begin
      load_ext = unsigned_q ? {32'h0, bus.mem_rdata}
                            : {{32{bus.mem_rdata[31]}}, bus.mem_rdata};
    end
  end

  // Load result: updated only by the final beat of a load, so stores leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 64'h0;
      lo_q  <= 32'h0;
    end else if (beat_ack && !write_q) begin
      if ((state_q == BEAT0) && (size_q == SZ_DWORD)) lo_q <= bus.mem_rdata;
      else if (state_q == BEAT1)                        rdata <= {bus.mem_rdata, lo_q};
      else                                              rdata <= load_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // The trap pulse lines up with the DONE cycle that directly follows IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= (state_q == IDLE) && access && acc_misaligned;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memwrite = 2'b00;
  logic        memread = 1'b0;
  logic [2:0]  readtype = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [63:0] wdata = 64'h0;
  logic        stall, done, misalign;
  logic [63:0] rdata;

  mem_access_unit_if #(.AW(32)) bus ();

  mem_access_unit #(.AW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .readtype(readtype), .addr(addr), .wdata(wdata), .stall(stall),
    .done(done), .rdata(rdata), .misalign(misalign), .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  // Memory slave: acks after wait_cfg idle request cycles, logs every beat.
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          nbeats = 0;
  int          beat_base = 0;
  logic [31:0] rd_q [2];
  logic [31:0] log_addr [64];
  logic [31:0] log_wdata [64];
  logic [3:0]  log_be [64];
  logic        log_we [64];

  always @(negedge clk) begin
    if (bus.mem_req && !reset) begin
      if (wcnt >= wait_cfg) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd_q[(nbeats - beat_base) % 2];
        log_addr[nbeats]  = bus.mem_addr;
        log_wdata[nbeats] = bus.mem_wdata;
        log_be[nbeats]    = bus.mem_be;
        log_we[nbeats]    = bus.mem_we;
        nbeats++;
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  int          done_cyc;
  int          stall_cnt;
  logic        req_seen;
  logic [63:0] rd_at_done;
  logic        mis_at_done;

  // Present one access for a single IDLE cycle and time its completion.
  // done_cyc counts cycles after acceptance; stall_cnt includes the accept cycle.
  task automatic run_access(input logic [1:0] mw, input logic mr, input logic [2:0] rt,
                            input logic [31:0] a, input logic [63:0] wd, input int waits,
                            input logic [31:0] r0, input logic [31:0] r1);
    @(posedge clk);
    @(negedge clk);
    wait_cfg = waits;
    beat_base = nbeats;
    rd_q[0] = r0;
    rd_q[1] = r1;
    memwrite = mw; memread = mr; readtype = rt; addr = a; wdata = wd;
    #1;
    stall_cnt = stall ? 1 : 0;
    req_seen = bus.mem_req;
    @(posedge clk);
    #1;
    memwrite = 2'b00; memread = 1'b0;
    done_cyc = -1;
    rd_at_done = 64'h0;
    mis_at_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        done_cyc = k;
        rd_at_done = rdata;
        mis_at_done = misalign;
        break;
      end
      if (stall) stall_cnt++;
      req_seen = req_seen | bus.mem_req;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    memread = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total++; if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
    total++; if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign); else pass_cnt++;
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_loads();
    run_access(2'b00, 1'b1, 3'b000, 32'h100, 64'h0, 0, 32'h8000_0001, 32'h0);
    total++; if (rd_at_done !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw_rdata: got %h want ffffffff80000001", rd_at_done); else pass_cnt++;
    total++; if (done_cyc !== 2) $display("FAIL lw_latency: got %0d want 2", done_cyc); else pass_cnt++;
    total++; if (stall_cnt !== 2) $display("FAIL lw_stall_cycles: got %0d want 2", stall_cnt); else pass_cnt++;
    total++; if (nbeats - beat_base !== 1) $display("FAIL lw_beats: got %0d want 1", nbeats - beat_base); else pass_cnt++;
    total++; if ({log_addr[beat_base], log_be[beat_base], log_we[beat_base]} !== {32'h100, 4'b1111, 1'b0})
      $display("FAIL lw_bus: got addr %h be %b we %b want 100 1111 0", log_addr[beat_base], log_be[beat_base], log_we[beat_base]); else pass_cnt++;
    run_access(2'b00, 1'b1, 3'b001, 32'h104, 64'h0, 1, 32'h8000_0001, 32'h0);
    total++; if (rd_at_done !== 64'h0000_0000_8000_0001) $display("FAIL lwu_rdata: got %h want 0000000080000001", rd_at_done); else pass_cnt++;
    total++; if (done_cyc !== 3) $display("FAIL lwu_latency_1wait: got %0d want 3", done_cyc); else pass_cnt++;
  endtask

  task automatic test_byte_loads();
    run_access(2'b00, 1'b1, 3'b011, 32'h103, 64'h0, 0, 32'h9A00_0000, 32'h0);
    total++; if (rd_at_done !== 64'h0000_0000_0000_009A) $display("FAIL lbu_rdata: got %h want 000000000000009a", rd_at_done); else pass_cnt++;
    total++; if (log_addr[beat_base] !== 32'h100) $display("FAIL lbu_addr: got %h want 100", log_addr[beat_base]); else pass_cnt++;
    run_access(2'b00, 1'b1, 3'b010, 32'h103, 64'h0, 0, 32'h9A00_0000, 32'h0);
    total++; if (rd_at_done !== 64'hFFFF_FFFF_FFFF_FF9A) $display("FAIL lb_rdata: got %h want ffffffffffffff9a", rd_at_done); else pass_cnt++;
    run_access(2'b00, 1'b1, 3'b010, 32'h101, 64'h0, 0, 32'h0000_7F00, 32'h0);
    total++; if (rd_at_done !== 64'h0000_0000_0000_007F) $display("FAIL lb_lane1_rdata: got %h want 000000000000007f", rd_at_done); else pass_cnt++;
  endtask

  task automatic test_doubleword();
    // Two wait states per beat: each beat is 3 request cycles, 6 stalled bus cycles.
    run_access(2'b11, 1'b0, 3'b000, 32'h200, 64'h1122_3344_5566_7788, 2, 32'h0, 32'h0);
    total++; if (nbeats - beat_base !== 2) $display("FAIL sd_beats: got %0d want 2", nbeats - beat_base); else pass_cnt++;
    total++; if ({log_addr[beat_base], log_wdata[beat_base], log_be[beat_base], log_we[beat_base]} !== {32'h200, 32'h5566_7788, 4'b1111, 1'b1})
      $display("FAIL sd_beat0: got %h %h %b %b want 200 55667788 1111 1", log_addr[beat_base], log_wdata[beat_base], log_be[beat_base], log_we[beat_base]); else pass_cnt++;
    total++; if ({log_addr[beat_base+1], log_wdata[beat_base+1], log_be[beat_base+1], log_we[beat_base+1]} !== {32'h204, 32'h1122_3344, 4'b1111, 1'b1})
      $display("FAIL sd_beat1: got %h %h %b %b want 204 11223344 1111 1", log_addr[beat_base+1], log_wdata[beat_base+1], log_be[beat_base+1], log_we[beat_base+1]); else pass_cnt++;
    total++; if (stall_cnt - 1 !== 6) $display("FAIL sd_stall_after_accept: got %0d want 6", stall_cnt - 1); else pass_cnt++;
    total++; if (done_cyc !== 7) $display("FAIL sd_latency: got %0d want 7", done_cyc); else pass_cnt++;
    total++; if (rd_at_done !== 64'h0000_0000_0000_007F) $display("FAIL sd_rdata_kept: got %h want 000000000000007f", rd_at_done); else pass_cnt++;
    run_access(2'b00, 1'b1, 3'b100, 32'h208, 64'h0, 0, 32'hAAAA_0001, 32'hBBBB_0002);
    total++; if (rd_at_done !== 64'hBBBB_0002_AAAA_0001) $display("FAIL ld_rdata: got %h want bbbb0002aaaa0001", rd_at_done); else pass_cnt++;
    total++; if (done_cyc !== 3) $display("FAIL ld_latency: got %0d want 3", done_cyc); else pass_cnt++;
    total++; if (log_addr[beat_base+1] !== 32'h20C) $display("FAIL ld_beat1_addr: got %h want 20c", log_addr[beat_base+1]); else pass_cnt++;
  endtask

  task automatic test_byte_store();
    run_access(2'b10, 1'b0, 3'b000, 32'h302, 64'hFFFF_FFFF_FFFF_FFAB, 0, 32'h0, 32'h0);
    total++; if (log_wdata[beat_base] !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want abababab", log_wdata[beat_base]); else pass_cnt++;
    total++; if (log_be[beat_base] !== 4'b0100) $display("FAIL sb_be: got %b want 0100", log_be[beat_base]); else pass_cnt++;
    total++; if ({log_addr[beat_base], log_we[beat_base]} !== {32'h300, 1'b1}) $display("FAIL sb_addr_we: got %h %b want 300 1", log_addr[beat_base], log_we[beat_base]); else pass_cnt++;
    total++; if (rd_at_done !== 64'hBBBB_0002_AAAA_0001) $display("FAIL sb_rdata_kept: got %h want bbbb0002aaaa0001", rd_at_done); else pass_cnt++;
    // Store and load together: the store must win.
    run_access(2'b01, 1'b1, 3'b000, 32'h310, 64'h0000_0000_CAFE_F00D, 0, 32'h1111_1111, 32'h0);
    total++; if ({log_we[beat_base], log_wdata[beat_base]} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL sw_priority: got %b %h want 1 cafef00d", log_we[beat_base], log_wdata[beat_base]); else pass_cnt++;
  endtask

  task automatic test_misalign();
    run_access(2'b00, 1'b1, 3'b000, 32'h101, 64'h0, 0, 32'h1234_5678, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (req_seen !== 1'b0) $display("FAIL mis_no_req: got %b want 0", req_seen); else pass_cnt++;
    total++; if (mis_at_done !== 1'b1) $display("FAIL mis_pulse: got %b want 1", mis_at_done); else pass_cnt++;
    total++; if (done_cyc !== 1) $display("FAIL mis_latency: got %0d want 1", done_cyc); else pass_cnt++;
    total++; if (rd_at_done !== 64'hBBBB_0002_AAAA_0001) $display("FAIL mis_rdata_kept: got %h want bbbb0002aaaa0001", rd_at_done); else pass_cnt++;
`else
    total++; if (log_addr[beat_base] !== 32'h100) $display("FAIL mis_aligned_addr: got %h want 100", log_addr[beat_base]); else pass_cnt++;
    total++; if (mis_at_done !== 1'b0) $display("FAIL mis_tied_low: got %b want 0", mis_at_done); else pass_cnt++;
    total++; if (done_cyc !== 2) $display("FAIL mis_latency: got %0d want 2", done_cyc); else pass_cnt++;
    total++; if (rd_at_done !== 64'h0000_0000_1234_5678) $display("FAIL mis_rdata: got %h want 0000000012345678", rd_at_done); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(posedge clk);
    @(negedge clk);
    wait_cfg = 3;
    beat_base = nbeats;
    rd_q[0] = 32'h5555_5555;
    rd_q[1] = 32'h6666_6666;
    memread = 1'b1; readtype = 3'b100; addr = 32'h400;
    @(posedge clk);
    #1;
    memread = 1'b0;
    for (int k = 0; k < 30 && (nbeats - beat_base) < 1; k++) @(negedge clk);
    total++; if (nbeats - beat_base !== 1) $display("FAIL rst_mid_beat0: got %0d beats want 1", nbeats - beat_base); else pass_cnt++;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mid_req: got %b want 0", bus.mem_req); else pass_cnt++;
    total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b want 0", stall); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    total++; if (seen_done !== 1'b0) $display("FAIL rst_mid_no_done: got %b want 0", seen_done); else pass_cnt++;
    total++; if (nbeats - beat_base !== 1) $display("FAIL rst_mid_no_more_beats: got %0d want 1", nbeats - beat_base); else pass_cnt++;
    run_access(2'b00, 1'b1, 3'b000, 32'h500, 64'h0, 0, 32'h0000_0007, 32'h0);
    total++; if ({done_cyc, rd_at_done} !== {32'sd2, 64'h7}) $display("FAIL rst_mid_recover: got %0d %h want 2 0000000000000007", done_cyc, rd_at_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_word_loads();
    test_byte_loads();
    test_doubleword();
    test_byte_store();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Executes the load/store operations selected by the main decoder's memory controls (`memwrite`, `readtype`, `memread`) against a 32-bit handshaked data-memory bus. Doubleword accesses are split into two bus beats. Byte lanes are steered and load results are sign- or zero-extended to 64 bits. The core is stalled until the access completes; the unit sits between the pipeline's memory stage and the data memory.

## Interface
- `AW`, 32, byte-address width of `addr` and `mem_addr`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `memwrite` input 2: store size; 00 none, 01 word (SW), 10 byte (SB), 11 doubleword (SD).
- `memread` input 1: load request.
- `readtype` input 3: load kind; 000 LW, 001 LWU, 010 LB, 011 LBU, 100 LD; 101–111 treated as LW.
- `addr` input AW: effective byte address from the ALU.
- `wdata` input 64: store data.
- `stall` output 1: core must hold the memory stage.
- `done` output 1: one-cycle pulse when an access finishes.
- `rdata` output 64: extended load result, valid while `done`=1 and held until the next load completes.
- `misalign` output 1: one-cycle pulse flagging a rejected access.
- `mem_req` output 1: bus request.
- `mem_we` output 1: write when 1.
- `mem_addr` output AW: word address, bits [1:0] always 0.
- `mem_be` output 4: byte enables, little-endian.
- `mem_wdata` output 32: write data.
- `mem_ack` input 1: slave completes the beat in this cycle.
- `mem_rdata` input 32: read data, valid with `mem_ack`.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- **Access present:** `memread`=1 or `memwrite`≠00. If both are asserted, the write wins.
- **IDLE:**
  - With an access present, the unit captures `addr`, `wdata`, type and size, then moves to BEAT0.
  - In that same cycle, `stall`=1.
- **BEAT0:**
  - `mem_req`=1 and `mem_addr`={addr[AW-1:2],2'b00}.
  - On `mem_ack`, the FSM goes to BEAT1 for doubleword accesses and to DONE otherwise.
- **BEAT1:**
  - `mem_req`=1 and `mem_addr`=beat-0 address+4.
  - On `mem_ack`, the FSM goes to DONE.
- **DONE:** `done`=1 and `stall`=0 for one cycle. No new access is accepted in this cycle, and the FSM returns to IDLE.
- `stall` = (IDLE & access present) | BEAT0 | BEAT1.
- **Stores:**
  - SW: `mem_be`=1111, `mem_wdata`=wdata[31:0].
  - SB: `wdata[7:0]` is replicated to all four lanes, `mem_be`=0001<<addr[1:0].
  - SD: beat 0 sends wdata[31:0], beat 1 sends wdata[63:32]; `mem_be`=1111 on both beats.
- **Loads:**
  - All loads use `mem_be`=1111.
  - LW sign-extends `mem_rdata`; LWU zero-extends it.
  - LB/LBU select byte lane addr[1:0], then sign- or zero-extend it.
  - LD: rdata={beat-1 data, beat-0 data}.
- Stores do not modify `rdata`.

## Timing
- **Reset values:** all registered outputs are 0 and the state is IDLE. `stall`=0 while `reset` is high.
- Bus outputs are registered. `mem_req` rises the cycle after the access is seen in IDLE.
- `mem_req` and the bus fields stay stable until the beat's `mem_ack`. `mem_ack` is ignored when `mem_req`=0.
- For doubleword accesses, `mem_req` remains high across the beat boundary, and the address updates the cycle after the first ack.
- **Latency with zero-wait ack (ack in the first `mem_req` cycle):**
  - Word/byte access: `done` 2 cycles after acceptance, `stall` high for 2 cycles.
  - Doubleword: `done` 3 cycles after acceptance.
- Each wait state adds one cycle.
- Reset mid-access drops `mem_req` immediately (asynchronous) and abandons the transfer.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - A word access with addr[1:0]≠0, or a doubleword access with addr[2:0]≠0, issues no bus beat.
  - The FSM goes from IDLE directly to DONE. `misalign` pulses with `done`, and `rdata` is unchanged.
  - Byte accesses never trap.
- **Not defined:** the offending low address bits are ignored (the access proceeds at the aligned address) and `misalign` is tied to 0.

## Test plan
- LW at 0x100 with zero-wait ack, `mem_rdata`=0x8000_0001 -> `rdata`=0xFFFF_FFFF_8000_0001, `done` on the 2nd cycle after acceptance.
- LBU at 0x103 with `mem_rdata`=0x9A00_0000 -> `rdata`=0x0000_0000_0000_009A; LB at the same address -> 0xFFFF_FFFF_FFFF_FF9A.
- SD at 0x200 with wdata=0x1122_3344_5566_7788 and 2 wait states per beat -> beats (0x200, 0x5566_7788) then (0x204, 0x1122_3344), `mem_be`=1111 on both, `stall` high for 6 cycles.
- SB at 0x302 with wdata[7:0]=0xAB -> `mem_wdata`=0xABAB_ABAB, `mem_be`=0100.
- LW at 0x101 -> with the macro: no `mem_req`, `misalign`=1 with `done`; without the macro: read at 0x100.
- Assert `reset` during the BEAT1 wait of an LD -> `mem_req`=0 immediately, state IDLE, `done` never pulses.
